spi_accel_responder: RTL and testbench

SPI_ACCEL_RESPONDER -- requirements
Module: spi_accel_responder

---
 rtl/spi_accel_pkg.sv | 62 ++++++
 rtl/spi_sync_edge.sv | 39 +++
 rtl/spi_accel_responder.sv | 244 ++++++++++++++++++++++++
 tb/tb_spi_accel_responder.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_accel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_accel_pkg
//  Description : Shared constants, state encoding and helpers for the SPI
//                accelerometer responder (register map, commands, IDs,
//                reset values).
//  Revision    : 1.0  initial release
// ============================================================================
package spi_accel_pkg;

    // Command bytes
    localparam logic [7:0] c_CMD_WRITE       = 8'h0A;
    localparam logic [7:0] c_CMD_READ        = 8'h0B;

    // Soft-reset key written to c_ADDR_SOFT_RESET
    localparam logic [7:0] c_SOFT_RESET_KEY  = 8'h52;

    // Register addresses (6-bit address space)
    localparam logic [5:0] c_ADDR_DEVID_AD   = 6'h00;
    localparam logic [5:0] c_ADDR_DEVID_MST  = 6'h01;
    localparam logic [5:0] c_ADDR_PARTID     = 6'h02;
    localparam logic [5:0] c_ADDR_REVID      = 6'h03;
    localparam logic [5:0] c_ADDR_XDATA      = 6'h08;
    localparam logic [5:0] c_ADDR_YDATA      = 6'h09;
    localparam logic [5:0] c_ADDR_ZDATA      = 6'h0A;
    localparam logic [5:0] c_ADDR_XDATA_L    = 6'h0E;
    localparam logic [5:0] c_ADDR_XDATA_H    = 6'h0F;
    localparam logic [5:0] c_ADDR_YDATA_L    = 6'h10;
    localparam logic [5:0] c_ADDR_YDATA_H    = 6'h11;
    localparam logic [5:0] c_ADDR_ZDATA_L    = 6'h12;
    localparam logic [5:0] c_ADDR_ZDATA_H    = 6'h13;
    localparam logic [5:0] c_ADDR_SOFT_RESET = 6'h1F;
    localparam logic [5:0] c_ADDR_FILTER_CTL = 6'h2C;
    localparam logic [5:0] c_ADDR_POWER_CTL  = 6'h2D;

    // Identification values
    localparam logic [7:0] c_DEVID_AD        = 8'hAD;
    localparam logic [7:0] c_DEVID_MST       = 8'h1D;
    localparam logic [7:0] c_PARTID          = 8'hF2;
    localparam logic [7:0] c_REVID           = 8'h01;

    // Control register reset values and writable-bit mask
    localparam logic [7:0] c_FILTER_CTL_RST  = 8'h13;
    localparam logic [7:0] c_POWER_CTL_RST   = 8'h00;
    localparam logic [7:0] c_POWER_CTL_MASK  = 8'h7F;

    // Transaction state machine encoding
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_SKIP = 3'd4
    } state_t;

    // Upper byte of a 12-bit sample: sign bits followed by bits [11:8]
    function automatic logic [7:0] sample_high_byte(input logic [11:0] v);
        return {{4{v[11]}}, v[11:8]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sync_edge
//  Description : Two-flop synchronizer for an asynchronous input with
//                single-cycle rise and fall pulses on the synchronized level.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronizer chain plus one delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_prev <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise =  r_sync & ~r_prev;
    assign o_fall = ~r_sync &  r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_accel_responder.sv
`default_nettype none
// ============================================================================
//  Module      : spi_accel_responder
//  Description : SPI mode-0 responder emulating an accelerometer register
//                file: command/address/data framing, coherent sample
//                snapshots, auto-incrementing bursts and control registers.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_accel_responder
    import spi_accel_pkg::*;
(
    input  logic               ClkPort,
    input  logic               ResetN,
    input  logic               aclSCLK,
    input  logic               aclMOSI,
    input  logic               aclSS,
    output logic               aclMISO,
    input  logic signed [11:0] accel_x,
    input  logic signed [11:0] accel_y,
    input  logic signed [11:0] accel_z,
    output logic [7:0]         power_ctl,
    output logic               busy,
    output logic               cmd_err
);

    logic        w_sclk_rise;
    logic        w_sclk_fall;
    logic        w_ss_rise;
    logic        w_ss_fall;

    logic        r_mosi_meta;
    logic        r_mosi_sync;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_cmd_bad;

    logic [2:0]  r_bit_cnt;
    logic [6:0]  r_shift;
    logic [5:0]  r_addr;
    logic        r_addr_null;
    logic        r_is_read;
    logic        r_load_pend;
    logic [7:0]  r_miso_sr;
    logic        r_miso;
    logic        r_busy;
    logic        r_cmd_err;
    logic [11:0] r_snap_x;
    logic [11:0] r_snap_y;
    logic [11:0] r_snap_z;
    logic [7:0]  r_filter_ctl;
    logic [7:0]  r_power_ctl;

    logic        w_bit_rise;
    logic        w_byte_done;
    logic [7:0]  w_byte;
    logic        w_wr_en;
    logic [7:0]  w_rd_data;

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
        .clk     (ClkPort),
        .rst_n   (ResetN),
        .i_async (aclSCLK),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b1)) u_ss_sync (
        .clk     (ClkPort),
        .rst_n   (ResetN),
        .i_async (aclSS),
        .o_rise  (w_ss_rise),
        .o_fall  (w_ss_fall)
    );

    // MOSI needs only the synchronizer; it is sampled on SCLK rise pulses
    always_ff @(posedge ClkPort or negedge ResetN) begin
        if (!ResetN) begin
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_mosi_meta <= aclMOSI;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    // A deselect in the same cycle as an SCLK edge suppresses that edge
    assign w_bit_rise  = w_sclk_rise && !w_ss_rise && (r_state != ST_IDLE);
    assign w_byte_done = w_bit_rise && (r_bit_cnt == 3'd7);
    assign w_byte      = {r_shift, r_mosi_sync};
    assign w_wr_en     = w_byte_done && (r_state == ST_DATA) && !r_is_read && !r_addr_null;

    // State register
    always_ff @(posedge ClkPort or negedge ResetN) begin
        if (!ResetN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; deselect returns to IDLE from any state
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_bad   = 1'b0;
        if (w_ss_rise) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_ss_fall) w_state_nxt = ST_CMD;
                ST_CMD: begin
                    if (w_byte_done) begin
                        if ((w_byte == c_CMD_READ) || (w_byte == c_CMD_WRITE)) begin
                            w_state_nxt = ST_ADDR;
                        end else begin
                            w_state_nxt = ST_SKIP;
                            w_cmd_bad   = 1'b1;
                        end
                    end
                end
                ST_ADDR: if (w_byte_done) w_state_nxt = ST_DATA;
                default: ;
            endcase
        end
    end

    // Read map; a null address (bits [7:6] set) reads zero
    always_comb begin
        w_rd_data = 8'h00;
        if (!r_addr_null) begin
            case (r_addr)
                c_ADDR_DEVID_AD:   w_rd_data = c_DEVID_AD;
                c_ADDR_DEVID_MST:  w_rd_data = c_DEVID_MST;
                c_ADDR_PARTID:     w_rd_data = c_PARTID;
                c_ADDR_REVID:      w_rd_data = c_REVID;
                c_ADDR_XDATA:      w_rd_data = r_snap_x[11:4];
                c_ADDR_YDATA:      w_rd_data = r_snap_y[11:4];
                c_ADDR_ZDATA:      w_rd_data = r_snap_z[11:4];
                c_ADDR_XDATA_L:    w_rd_data = r_snap_x[7:0];
                c_ADDR_XDATA_H:    w_rd_data = sample_high_byte(r_snap_x);
                c_ADDR_YDATA_L:    w_rd_data = r_snap_y[7:0];
                c_ADDR_YDATA_H:    w_rd_data = sample_high_byte(r_snap_y);
                c_ADDR_ZDATA_L:    w_rd_data = r_snap_z[7:0];
                c_ADDR_ZDATA_H:    w_rd_data = sample_high_byte(r_snap_z);
                c_ADDR_FILTER_CTL: w_rd_data = r_filter_ctl;
                c_ADDR_POWER_CTL:  w_rd_data = r_power_ctl;
                default:           w_rd_data = 8'h00;
            endcase
        end
    end

    // Shift, address, snapshot and MISO datapath
    always_ff @(posedge ClkPort or negedge ResetN) begin
        if (!ResetN) begin
            r_bit_cnt   <= 3'd0;
            r_shift     <= 7'd0;
            r_addr      <= 6'd0;
            r_addr_null <= 1'b0;
            r_is_read   <= 1'b0;
            r_load_pend <= 1'b0;
            r_miso_sr   <= 8'h00;
            r_miso      <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_snap_x    <= 12'd0;
            r_snap_y    <= 12'd0;
            r_snap_z    <= 12'd0;
        end else begin
            r_cmd_err <= w_cmd_bad;
            if (w_ss_rise) begin
                r_bit_cnt   <= 3'd0;
                r_busy      <= 1'b0;
                r_miso      <= 1'b0;
                r_load_pend <= 1'b0;
            end else if (w_ss_fall && (r_state == ST_IDLE)) begin
                r_bit_cnt   <= 3'd0;
                r_busy      <= 1'b1;
                r_miso      <= 1'b0;
                r_load_pend <= 1'b0;
                r_snap_x    <= accel_x;
                r_snap_y    <= accel_y;
                r_snap_z    <= accel_z;
            end else begin
                if (w_bit_rise) begin
                    r_shift   <= w_byte[6:0];
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                if (w_byte_done) begin
                    case (r_state)
                        ST_CMD:  r_is_read <= (w_byte == c_CMD_READ);
                        ST_ADDR: begin
                            r_addr      <= w_byte[5:0];
                            r_addr_null <= |w_byte[7:6];
                            r_load_pend <= r_is_read;
                        end
                        ST_DATA: begin
                            r_addr      <= r_addr + 6'd1;
                            r_load_pend <= r_is_read;
                        end
                        default: ;
                    endcase
                end
                // MISO only moves on SCLK falls during a read data phase
                if (w_sclk_fall && (r_state == ST_DATA) && r_is_read) begin
                    if (r_load_pend) begin
                        r_miso      <= w_rd_data[7];
                        r_miso_sr   <= {w_rd_data[6:0], 1'b0};
                        r_load_pend <= 1'b0;
                    end else begin
                        r_miso    <= r_miso_sr[7];
                        r_miso_sr <= {r_miso_sr[6:0], 1'b0};
                    end
                end
            end
        end
    end

    // Control registers, committed only on a complete write byte
    always_ff @(posedge ClkPort or negedge ResetN) begin
        if (!ResetN) begin
            r_filter_ctl <= c_FILTER_CTL_RST;
            r_power_ctl  <= c_POWER_CTL_RST;
        end else if (w_wr_en) begin
            case (r_addr)
                c_ADDR_FILTER_CTL: r_filter_ctl <= w_byte;
                c_ADDR_POWER_CTL:  r_power_ctl  <= w_byte & c_POWER_CTL_MASK;
                c_ADDR_SOFT_RESET: begin
                    if (w_byte == c_SOFT_RESET_KEY) begin
                        r_filter_ctl <= c_FILTER_CTL_RST;
                        r_power_ctl  <= c_POWER_CTL_RST;
                    end
                end
                default: ;
            endcase
        end
    end

    assign aclMISO   = r_miso;
    assign busy      = r_busy;
    assign cmd_err   = r_cmd_err;
    assign power_ctl = r_power_ctl;

endmodule
`default_nettype wire

// File: tb/tb_spi_accel_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_accel_responder
//  Description : Self-checking bench for spi_accel_responder: directed
//                scenarios followed by randomized bursts against a
//                behavioural register-map model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_accel_responder;

    localparam int HALF = 6;   // SCLK half period in system clocks

    logic               ClkPort = 1'b0;
    logic               ResetN;
    logic               aclSCLK;
    logic               aclMOSI;
    logic               aclSS;
    logic               aclMISO;
    logic signed [11:0] accel_x;
    logic signed [11:0] accel_y;
    logic signed [11:0] accel_z;
    logic [7:0]         power_ctl;
    logic               busy;
    logic               cmd_err;

    int total = 0;
    int bad   = 0;

    int   err_pulses = 0;
    int   miso_hi    = 0;
    logic watch_miso = 1'b0;

    // Reference model state
    logic [7:0]  m_power;
    logic [7:0]  m_filter;
    logic [11:0] m_x, m_y, m_z;

    logic [7:0] rbuf [8];
    logic [7:0] wbuf [8];

    spi_accel_responder dut (
        .ClkPort   (ClkPort),
        .ResetN    (ResetN),
        .aclSCLK   (aclSCLK),
        .aclMOSI   (aclMOSI),
        .aclSS     (aclSS),
        .aclMISO   (aclMISO),
        .accel_x   (accel_x),
        .accel_y   (accel_y),
        .accel_z   (accel_z),
        .power_ctl (power_ctl),
        .busy      (busy),
        .cmd_err   (cmd_err)
    );

    always #5 ClkPort = ~ClkPort;

    always @(negedge ClkPort) begin
        if (cmd_err) err_pulses <= err_pulses + 1;
        if (watch_miso && aclMISO) miso_hi <= miso_hi + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Register contents as an accelerometer reader sees them
    function automatic logic [7:0] model_read(input int a);
        int sx, sy, sz;
        sx = int'($signed(m_x));
        sy = int'($signed(m_y));
        sz = int'($signed(m_z));
        case (a)
            'h00: return 8'hAD;
            'h01: return 8'h1D;
            'h02: return 8'hF2;
            'h03: return 8'h01;
            'h08: return 8'((sx >>> 4) & 255);
            'h09: return 8'((sy >>> 4) & 255);
            'h0A: return 8'((sz >>> 4) & 255);
            'h0E: return 8'(sx & 255);
            'h0F: return 8'((sx >>> 8) & 255);
            'h10: return 8'(sy & 255);
            'h11: return 8'((sy >>> 8) & 255);
            'h12: return 8'(sz & 255);
            'h13: return 8'((sz >>> 8) & 255);
            'h2C: return m_filter;
            'h2D: return m_power;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_write(input int a, input logic [7:0] d);
        case (a)
            'h2C: m_filter = d;
            'h2D: m_power  = d & 8'h7F;
            'h1F: if (d == 8'h52) begin
                m_filter = 8'h13;
                m_power  = 8'h00;
            end
            default: ;
        endcase
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge ClkPort);
    endtask

    // Mode-0 initiator: data set while SCLK low, MISO captured at the rise
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            aclMOSI = tx[7-i];
            tick(HALF);
            rx = {rx[6:0], aclMISO};
            aclSCLK = 1'b1;
            tick(HALF);
            aclSCLK = 1'b0;
        end
    endtask

    task automatic ss_low();
        aclSS = 1'b0;
        m_x = accel_x;
        m_y = accel_y;
        m_z = accel_z;
        tick(HALF);
    endtask

    task automatic ss_high();
        tick(HALF);
        aclSS = 1'b1;
        tick(HALF);
    endtask

    task automatic rd_burst(input logic [7:0] abyte, input int n, input bit mid_change);
        logic [7:0] r;
        ss_low();
        xfer(8'h0B, 8, r);
        xfer(abyte, 8, r);
        for (int i = 0; i < n; i++) begin
            xfer(8'h00, 8, r);
            rbuf[i] = r;
            if (mid_change && i == 0) begin
                accel_x = 12'($urandom);
                accel_y = 12'($urandom);
                accel_z = 12'($urandom);
            end
        end
        ss_high();
    endtask

    task automatic wr_burst(input logic [7:0] abyte, input int n);
        logic [7:0] r;
        ss_low();
        xfer(8'h0A, 8, r);
        xfer(abyte, 8, r);
        for (int i = 0; i < n; i++) begin
            xfer(wbuf[i], 8, r);
            if (abyte[7:6] == 2'b00) model_write((int'(abyte[5:0]) + i) % 64, wbuf[i]);
        end
        ss_high();
    endtask

    initial begin
        logic [7:0] r;
        int         e0;
        int         a, n, sel;

        ResetN  = 1'b0;
        aclSCLK = 1'b0;
        aclMOSI = 1'b0;
        aclSS   = 1'b1;
        accel_x = 12'sd0;
        accel_y = 12'sd0;
        accel_z = 12'sd0;
        m_power  = 8'h00;
        m_filter = 8'h13;
        tick(5);

        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_miso", 32'(aclMISO), 32'd0);
        chk("rst_cmd_err", 32'(cmd_err), 32'd0);
        chk("rst_power", 32'(power_ctl), 32'h00);
        ResetN = 1'b1;
        tick(5);
        rd_burst(8'h2C, 1, 1'b0);
        chk("rst_filter", 32'(rbuf[0]), 32'h13);

        // ID read with a busy check mid-transaction
        ss_low();
        chk("busy_active", 32'(busy), 32'd1);
        xfer(8'h0B, 8, r);
        xfer(8'h00, 8, r);
        for (int i = 0; i < 4; i++) begin
            xfer(8'h00, 8, r);
            rbuf[i] = r;
        end
        ss_high();
        chk("id0", 32'(rbuf[0]), 32'hAD);
        chk("id1", 32'(rbuf[1]), 32'h1D);
        chk("id2", 32'(rbuf[2]), 32'hF2);
        chk("id3", 32'(rbuf[3]), 32'h01);
        chk("busy_idle", 32'(busy), 32'd0);

        // Coherent burst: sample changes after the first byte
        accel_x = 12'h8A5;
        ss_low();
        xfer(8'h0B, 8, r);
        xfer(8'h0E, 8, r);
        xfer(8'h00, 8, r);
        rbuf[0] = r;
        accel_x = 12'h123;
        xfer(8'h00, 8, r);
        rbuf[1] = r;
        ss_high();
        chk("coh_lo", 32'(rbuf[0]), 32'hA5);
        chk("coh_hi", 32'(rbuf[1]), 32'hF8);

        // Write then read back POWER_CTL; bit 7 not writable
        wbuf[0] = 8'hFF;
        wr_burst(8'h2D, 1);
        chk("pwr_wr", 32'(power_ctl), 32'h7F);
        rd_burst(8'h2D, 1, 1'b0);
        chk("pwr_rd", 32'(rbuf[0]), 32'h7F);

        // FILTER_CTL write, then soft reset
        wbuf[0] = 8'h55;
        wr_burst(8'h2C, 1);
        rd_burst(8'h2C, 1, 1'b0);
        chk("flt_rd", 32'(rbuf[0]), 32'h55);
        wbuf[0] = 8'h52;
        wr_burst(8'h1F, 1);
        chk("srst_pwr", 32'(power_ctl), 32'h00);
        rd_burst(8'h2C, 1, 1'b0);
        chk("srst_flt", 32'(rbuf[0]), 32'h13);

        // Aborted partial write byte is discarded
        wbuf[0] = 8'h25;
        wr_burst(8'h2D, 1);
        chk("pwr_25", 32'(power_ctl), 32'h25);
        ss_low();
        xfer(8'h0A, 8, r);
        xfer(8'h2D, 8, r);
        xfer(8'h7A, 5, r);
        ss_high();
        chk("abort_pwr", 32'(power_ctl), 32'h25);

        // Unknown command: one cmd_err pulse, MISO silent, nothing written
        e0 = err_pulses;
        watch_miso = 1'b1;
        ss_low();
        xfer(8'h5A, 8, r);
        xfer(8'h2D, 8, r);
        xfer(8'hFF, 8, r);
        ss_high();
        watch_miso = 1'b0;
        chk("bad_cmd_pulse", 32'(err_pulses - e0), 32'd1);
        chk("bad_cmd_miso", 32'(miso_hi), 32'd0);
        chk("bad_cmd_pwr", 32'(power_ctl), 32'h25);

        // Null addresses: reads zero, writes ignored
        rd_burst(8'h40, 1, 1'b0);
        chk("null_rd", 32'(rbuf[0]), 32'h00);
        wbuf[0] = 8'h11;
        wr_burst(8'hED, 1);
        chk("null_wr", 32'(power_ctl), 32'h25);

        // Address wrap 0x3F -> 0x00
        rd_burst(8'h3F, 2, 1'b0);
        chk("wrap0", 32'(rbuf[0]), 32'h00);
        chk("wrap1", 32'(rbuf[1]), 32'hAD);

        // Randomized bursts against the model
        for (int it = 0; it < 24; it++) begin
            accel_x = 12'($urandom);
            accel_y = 12'($urandom);
            accel_z = 12'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                a = $urandom_range(0, 63);
                n = $urandom_range(1, 4);
                rd_burst(8'(a), n, 1'b1);
                for (int i = 0; i < n; i++)
                    chk($sformatf("rnd%0d_rd%0d_a%0h", it, i, (a + i) % 64),
                        32'(rbuf[i]), 32'(model_read((a + i) % 64)));
            end else begin
                sel = $urandom_range(0, 3);
                a = (sel == 0) ? 'h2C : (sel == 1) ? 'h2D : (sel == 2) ? 'h1F : $urandom_range(0, 63);
                n = $urandom_range(1, 3);
                for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
                if (a == 'h1F && $urandom_range(0, 1) == 1) wbuf[0] = 8'h52;
                wr_burst(8'(a), n);
                chk($sformatf("rnd%0d_pwr", it), 32'(power_ctl), 32'(m_power));
            end
        end
        rd_burst(8'h2C, 2, 1'b0);
        chk("rnd_final_flt", 32'(rbuf[0]), 32'(m_filter));
        chk("rnd_final_pwr", 32'(rbuf[1]), 32'(m_power));

        // Reset asserted mid-burst clears outputs immediately
        ss_low();
        xfer(8'h0B, 8, r);
        xfer(8'h00, 8, r);
        tick(HALF);
        chk("pre_rst_miso", 32'(aclMISO), 32'd1);
        ResetN = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_miso", 32'(aclMISO), 32'd0);
        chk("mid_rst_pwr", 32'(power_ctl), 32'h00);
        aclSS = 1'b1;
        tick(3);
        ResetN = 1'b1;
        m_power  = 8'h00;
        m_filter = 8'h13;
        tick(5);
        rd_burst(8'h2C, 1, 1'b0);
        chk("post_rst_flt", 32'(rbuf[0]), 32'h13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
